// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: opcodes, command kinds, encoder FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package mips_pkg;

    // Primary opcode field (bits 31:26) for the four supported formats
    localparam logic [5:0] OP_RFMT = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    // Symbolic command kind as presented on cmd_kind
    typedef enum logic [1:0] {
        KIND_R   = 2'd0,
        KIND_LW  = 2'd1,
        KIND_SW  = 2'd2,
        KIND_BNE = 2'd3
    } cmd_kind_e;

    // Loader session state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // Opcode for a command kind
    function automatic logic [5:0] kind_opcode(input cmd_kind_e kind);
        case (kind)
            KIND_LW:  return OP_LW;
            KIND_SW:  return OP_SW;
            KIND_BNE: return OP_BNE;
            default:  return OP_RFMT;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs a symbolic command (kind + fields) into a 32-bit MIPS instruction word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module instr_pack
    import mips_pkg::*;
(
    input  logic [1:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word
);

    cmd_kind_e w_kind;
    assign w_kind = cmd_kind_e'(i_kind);

    // R-format uses rd/shamt/funct; the I-format kinds share one layout with the immediate
    always_comb begin
        o_word = '0;
        case (w_kind)
            KIND_R:                     o_word = {OP_RFMT, i_rs, i_rt, i_rd, i_shamt, i_funct};
            KIND_LW, KIND_SW, KIND_BNE: o_word = {kind_opcode(w_kind), i_rs, i_rt, i_imm};
            default:                    o_word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction loader: encodes commands and writes them to consecutive imem addresses.
// Latency: command accepted in cycle N is presented as imem_we=1 in cycle N+1; one word/cycle.
// Backpressure: imem_ready=0 holds the output register and drops cmd_ready; cmd_ready also low after last/full.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic              cmd_last,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [5:0]        cmd_funct,
    input  logic [15:0]       cmd_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_ADR_ONE  = ADDR_W'(1);

    enc_state_e        r_state;
    enc_state_e        w_state_nxt;
    logic              r_we;
    logic              r_out_last;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W:0]   r_issued;
    logic              r_done;
    logic              r_overflow;

    logic [31:0]       w_word;
    logic              w_cmd_acc;
    logic              w_wr_acc;
    logic              w_final;
    logic              w_start_sess;

    instr_pack u_pack (
        .i_kind  (cmd_kind),
        .i_rs    (cmd_rs),
        .i_rt    (cmd_rt),
        .i_rd    (cmd_rd),
        .i_shamt (cmd_shamt),
        .i_funct (cmd_funct),
        .i_imm   (cmd_imm),
        .o_word  (w_word)
    );

    assign w_cmd_acc    = cmd_valid && cmd_ready;
    assign w_wr_acc     = r_we && imem_ready;
    // Session ends on the last-tagged word, or on the final slot when no last tag arrived
    assign w_final      = w_wr_acc && (r_out_last || (r_word_count == LP_LAST_IDX));
    // start is ignored while a session is running
    assign w_start_sess = start && (r_state != ST_RUN);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: start opens a session, the final accepted write closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)   w_state_nxt = ST_RUN;
            ST_RUN:  if (w_final) w_state_nxt = ST_DONE;
            ST_DONE: if (start)   w_state_nxt = ST_RUN;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when the output slot frees up, no last word is pending and slots remain
    always_comb begin
        busy      = (r_state == ST_RUN);
        cmd_ready = (r_state == ST_RUN) && (!r_we || imem_ready)
                    && !(r_we && r_out_last) && (r_issued < LP_DEPTH);
    end

    // Output register: load on command acceptance, drop valid once the word is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_out_last <= 1'b0;
            r_wdata    <= '0;
        end else if (w_cmd_acc) begin
            r_we       <= 1'b1;
            r_out_last <= cmd_last;
            r_wdata    <= w_word;
        end else if (w_wr_acc) begin
            r_we       <= 1'b0;
        end
    end

    // Session counters and sticky status; address holds on the final write so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_issued     <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_start_sess) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_issued     <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_cmd_acc) r_issued <= r_issued + LP_CNT_ONE;
            if (w_wr_acc) begin
                r_word_count <= r_word_count + LP_CNT_ONE;
                if (!w_final) r_addr <= r_addr + LP_ADR_ONE;
            end
            if (w_final) begin
                r_done     <= 1'b1;
                r_overflow <= !r_out_last;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a queue-based reference of expected memory writes.
// Latency: n/a.
// Backpressure: bench drives imem_ready directly to create stalls.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_kind = '0;
    logic              cmd_last = 1'b0;
    logic [4:0]        cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
    logic [5:0]        cmd_funct = '0;
    logic [15:0]       cmd_imm = '0;
    logic              imem_we;
    logic              imem_ready = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   word_count;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_last(cmd_last),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
        .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    int                n_pass = 0;
    int                n_chk = 0;
    int                m_addr = 0;
    int                wr_total = 0;
    int                cyc = 0;
    logic [ADDR_W-1:0] log_addr [0:63];
    logic [31:0]       log_data [0:63];
    int                log_cyc  [0:63];
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]       prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference encoding from field positions, written arithmetically
    function automatic logic [31:0] ref_enc(input int kind, input int rs, input int rt, input int rd,
                                            input int sh, input int fn, input int imm);
        int op;
        case (kind)
            0:       op = 0;
            1:       op = 35;
            2:       op = 43;
            default: op = 5;
        endcase
        if (kind == 0) return 32'((rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
        return 32'((op << 26) + (rs << 21) + (rt << 16) + imm);
    endfunction

    always @(posedge clk) cyc++;

    // Compare process: every accepted write must match the oldest expected write; stalls must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && imem_we) begin
                chk("stall_addr_stable", 32'(imem_addr), 32'(prev_addr));
                chk("stall_data_stable", imem_wdata, prev_data);
            end
            if (imem_we && !imem_ready) chk("stall_cmd_ready_low", 32'(cmd_ready), 32'd0);
            prev_stall = imem_we && !imem_ready;
            prev_addr  = imem_addr;
            prev_data  = imem_wdata;
            if (imem_we && imem_ready) begin
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("write_addr", 32'(imem_addr), 32'(exp_q[0].addr));
                    chk("write_data", imem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                if (wr_total < 64) begin
                    log_addr[wr_total] = imem_addr;
                    log_data[wr_total] = imem_wdata;
                    log_cyc[wr_total]  = cyc;
                end
                wr_total++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd, input int sh,
                        input int fn, input int imm, input bit last, output bit acc);
        wr_t e;
        cmd_kind  = 2'(kind);
        cmd_rs    = 5'(rs);
        cmd_rt    = 5'(rt);
        cmd_rd    = 5'(rd);
        cmd_shamt = 5'(sh);
        cmd_funct = 6'(fn);
        cmd_imm   = 16'(imm);
        cmd_last  = last;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            step();
        end
        if (acc) begin
            e.addr = ADDR_W'(m_addr);
            e.data = ref_enc(kind, rs, rt, rd, sh, fn, imm);
            exp_q.push_back(e);
            m_addr++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_ok(input string name, input int kind, input int rs, input int rt, input int rd,
                           input int sh, input int fn, input int imm, input bit last);
        bit acc;
        send(kind, rs, rt, rd, sh, fn, imm, last, acc);
        chk(name, 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(name, 32'(done), 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  nacc;
        bit  acc;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_word_count", 32'(word_count), 0);
        step();
        rst_n = 1'b1;
        step();

        // cmd_valid in IDLE is never accepted
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_cmd_ready", 32'(cmd_ready), 0);
            chk("idle_imem_we", 32'(imem_we), 0);
            step();
        end
        cmd_valid = 1'b0;
        chk("idle_no_writes", 32'(wr_total), 0);

        // Single R-format word with last
        imem_ready = 1'b1;
        do_start();
        @(negedge clk);
        chk("t1_busy", 32'(busy), 1);
        step();
        m_addr = 0;
        send_ok("t1_accept", 0, 1, 2, 3, 0, 32, 0, 1'b1);
        @(negedge clk);
        chk("t1_we_latency", 32'(imem_we), 1);
        chk("t1_addr", 32'(imem_addr), 0);
        chk("t1_wdata", imem_wdata, 32'h0022_1820);
        step();
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_word_count", 32'(word_count), 1);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_overflow", 32'(overflow), 0);
        step();

        // cmd_valid in DONE is never accepted
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("done_cmd_ready", 32'(cmd_ready), 0);
            chk("done_imem_we", 32'(imem_we), 0);
            step();
        end
        cmd_valid = 1'b0;

        // Back-to-back lw, sw, bne(last)
        do_start();
        m_addr = 0;
        base = wr_total;
        send_ok("t2_acc_lw", 1, 0, 8, 0, 0, 0, 4, 1'b0);
        send_ok("t2_acc_sw", 2, 0, 8, 0, 0, 0, 8, 1'b0);
        send_ok("t2_acc_bne", 3, 8, 9, 0, 0, 0, 16'hFFFE, 1'b1);
        wait_done("t2_done");
        chk("t2_nwrites", 32'(wr_total - base), 3);
        chk("t2_w0", log_data[base], 32'h8C08_0004);
        chk("t2_w1", log_data[base+1], 32'hAC08_0008);
        chk("t2_w2", log_data[base+2], 32'h1509_FFFE);
        chk("t2_a0", 32'(log_addr[base]), 0);
        chk("t2_a1", 32'(log_addr[base+1]), 1);
        chk("t2_a2", 32'(log_addr[base+2]), 2);
        chk("t2_consecutive", 32'(log_cyc[base+2] - log_cyc[base]), 2);
        chk("t2_word_count", 32'(word_count), 3);

        // Backpressure for 5 cycles with a word pending and a second command waiting
        do_start();
        m_addr = 0;
        base = wr_total;
        imem_ready = 1'b0;
        send_ok("t3_acc_first", 0, 5, 6, 7, 2, 34, 0, 1'b0);
        cmd_kind = 2'd1; cmd_rs = 5'd3; cmd_rt = 5'd4; cmd_imm = 16'h0010; cmd_last = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_we", 32'(imem_we), 1);
            chk("t3_hold_cmd_ready", 32'(cmd_ready), 0);
            chk("t3_hold_addr", 32'(imem_addr), 0);
            chk("t3_hold_data", imem_wdata, ref_enc(0, 5, 6, 7, 2, 34, 0));
            step();
        end
        imem_ready = 1'b1;
        send_ok("t3_acc_second", 1, 3, 4, 0, 0, 0, 16'h0010, 1'b1);
        wait_done("t3_done");
        chk("t3_nwrites", 32'(wr_total - base), 2);
        chk("t3_word_count", 32'(word_count), 2);
        chk("t3_queue_empty", 32'(exp_q.size()), 0);

        // Overflow: 6 commands without last into DEPTH=4
        do_start();
        m_addr = 0;
        base = wr_total;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1, 1, i, 0, 0, 0, i * 4, 1'b0, acc);
            nacc += int'(acc);
        end
        chk("t4_accepted", 32'(nacc), 4);
        wait_done("t4_done");
        @(negedge clk);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_cmd_ready", 32'(cmd_ready), 0);
        chk("t4_word_count", 32'(word_count), 4);
        chk("t4_nwrites", 32'(wr_total - base), 4);
        chk("t4_last_addr", 32'(log_addr[wr_total-1]), 3);
        chk("t4_queue_empty", 32'(exp_q.size()), 0);
        step();

        // Reset mid-session after 2 writes, third word pending
        do_start();
        m_addr = 0;
        base = wr_total;
        send_ok("t5_acc0", 0, 1, 1, 1, 0, 32, 0, 1'b0);
        send_ok("t5_acc1", 0, 2, 2, 2, 0, 32, 0, 1'b0);
        step();
        imem_ready = 1'b0;
        send_ok("t5_acc2", 0, 3, 3, 3, 0, 32, 0, 1'b0);
        chk("t5_two_written", 32'(wr_total - base), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(imem_we), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_cmd_ready", 32'(cmd_ready), 0);
        chk("t5_rst_addr", 32'(imem_addr), 0);
        chk("t5_rst_wdata", imem_wdata, 0);
        chk("t5_rst_word_count", 32'(word_count), 0);
        chk("t5_rst_done", 32'(done), 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        step();
        do_start();
        m_addr = 0;
        send_ok("t5_acc_new", 3, 2, 3, 0, 0, 0, 7, 1'b1);
        wait_done("t5_done");
        chk("t5_new_addr", 32'(log_addr[wr_total-1]), 0);
        chk("t5_new_data", log_data[wr_total-1], 32'h1443_0007);
        chk("t5_word_count", 32'(word_count), 1);

        // start pulsed during RUN is ignored
        do_start();
        m_addr = 0;
        send_ok("t6_acc0", 0, 10, 11, 12, 0, 37, 0, 1'b0);
        step();
        chk("t6_count_before", 32'(word_count), 1);
        do_start();
        @(negedge clk);
        chk("t6_busy_kept", 32'(busy), 1);
        chk("t6_count_kept", 32'(word_count), 1);
        chk("t6_done_low", 32'(done), 0);
        step();
        send_ok("t6_acc1", 2, 4, 5, 0, 0, 0, 32, 1'b1);
        wait_done("t6_done");
        chk("t6_addr", 32'(log_addr[wr_total-1]), 1);
        chk("t6_data", log_data[wr_total-1], 32'hAC85_0020);
        chk("t6_word_count", 32'(word_count), 2);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and instruction-memory loader: accepts symbolic instruction commands (kind, register fields, immediate) over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them to consecutive instruction-memory addresses. It produces the same four formats the main control decoder consumes (R-format, lw, sw, bne). It sits between the testbench/boot command source and the instruction memory write port, ahead of the pipeline.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `DEPTH`, 256: number of loadable words; must satisfy `DEPTH` ≤ 2^`ADDR_W`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; begins a load session at word address 0.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: encoder accepts the command this cycle.
- `cmd_kind` in 2: 0 = R-format, 1 = lw, 2 = sw, 3 = bne.
- `cmd_last` in 1: this command is the final word of the session.
- `cmd_rs`, `cmd_rt`, `cmd_rd` in 5 each: register fields.
- `cmd_shamt` in 5: shift amount (R only).
- `cmd_funct` in 6: function code (R only).
- `cmd_imm` in 16: immediate/offset (lw, sw, bne).
- `imem_we` out 1: write request, which equals the output-register valid bit.
- `imem_ready` in 1: memory accepts the write this cycle.
- `imem_addr` out ADDR_W: word address of the pending write.
- `imem_wdata` out 32: encoded instruction.
- `busy` out 1: session in progress.
- `done` out 1: session complete (sticky until the next `start`).
- `overflow` out 1: session ended because `DEPTH` was reached without `cmd_last` (sticky until the next `start`).
- `word_count` out ADDR_W+1: words written in the current or last session.

## Operation
- Encodings, bit 31 down to bit 0:
  - R: 000000, rs, rt, rd, shamt, funct.
  - lw: 100011, rs, rt, imm.
  - sw: 101011, rs, rt, imm.
  - bne: 000101, rs, rt, imm.
  - Fields that are unused by a kind are ignored.
- FSM states are IDLE, RUN, and DONE.
- Transitions:
  - IDLE → RUN on `start`. This clears `done`, `overflow`, `word_count`, and the address.
  - RUN → DONE when a write is accepted (`imem_we && imem_ready`) and either:
    - the accepted word carried `cmd_last`, or
    - the accepted write is word `DEPTH`-1 without `cmd_last`, which also sets `overflow`.
  - DONE → RUN on `start`.
- `start` while in RUN is ignored.
- `cmd_ready` = RUN && (!`imem_we` || `imem_ready`) && no accepted-but-unwritten `cmd_last` pending && issued words < `DEPTH`.
- A command is accepted when `cmd_valid && cmd_ready`. On the next edge it loads the output register: `imem_wdata`, its `cmd_last` tag, and `imem_we`=1.
- On a write acceptance:
  - `imem_addr` increments (no wrap: the session ends first).
  - `word_count` increments.
  - `imem_we` drops unless a new command is accepted in the same cycle.
- `busy` = (state == RUN).

## Timing
- Reset values:
  - FSM IDLE.
  - `cmd_ready`, `imem_we`, `busy`, `done`, `overflow` all 0.
  - `imem_addr` 0, `imem_wdata` 0, `word_count` 0.
- Latency: a command accepted in cycle N appears as `imem_we`=1 in cycle N+1.
- Throughput: one word per cycle while `imem_ready`=1.
- Backpressure: while `imem_we`=1 && `imem_ready`=0, the output register holds stable and `cmd_ready`=0.
- `done`/`overflow` assert in the cycle after the final write acceptance.
- Asserting `rst_n` low mid-session immediately clears all state; the session is lost and is not resumed.
- `cmd_valid` high in IDLE/DONE gets no acceptance and has no effect.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OP_RFMT`=6'b000000, `OP_LW`=6'b100011, `OP_SW`=6'b101011, `OP_BNE`=6'b000101;
  - the `cmd_kind` enumeration;
  - the FSM state encoding.
- The control decoder imports the same opcode constants.
- One combinational sub-module, `instr_pack`, maps kind and fields to the 32-bit word. The sequential logic (FSM, output register, counters) lives in `instr_encoder`.

## Test plan
- Reset then `start`. Send R(rs=1, rt=2, rd=3, shamt=0, funct=0x20, last) with `imem_ready`=1. Expect:
  - `imem_we` one cycle later;
  - addr 0, wdata 0x00221820;
  - then `done`=1 and `word_count`=1.
- Send lw(rs=0, rt=8, imm=4), sw(rs=0, rt=8, imm=8), bne(rs=8, rt=9, imm=0xFFFE, last) back-to-back. Expect:
  - words 0x8C080004, 0xAC080008, 0x1509FFFE at addresses 0, 1, 2 on consecutive cycles;
  - `word_count`=3.
- Hold `imem_ready`=0 for 5 cycles with a word pending. Expect:
  - `imem_wdata` and `imem_addr` stable;
  - `cmd_ready`=0;
  - no word lost or duplicated after release.
- With `DEPTH`=4, send 6 commands without `cmd_last`. Expect:
  - 4 writes at addresses 0–3;
  - `overflow`=1, `done`=1;
  - `cmd_ready`=0 afterward.
- Drop `rst_n` after 2 of 4 writes. Expect all outputs at reset values; a new `start` writes from address 0.
- Pulse `start` in RUN and drive `cmd_valid` in IDLE. Expect no state change and no acceptance.
